param_ram: RTL



---
 rtl/param_ram.sv | 109 ++++++++++
 1 files changed

// File: rtl/param_ram.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, 1- or 2-cycle read latency and a clear engine.
module param_ram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned WR_MODE    = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                ram_en,
  input  logic                ram_wea,
  input  logic [DATA_W/8-1:0] ram_be,
  input  logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_wr_data,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   ram_rd_data,
  output logic                ram_rd_valid,
  output logic                ram_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_c, wr_c;
  logic [DATA_W-1:0] old_c, merged_c, ret_c;

  // Access qualification, byte-lane merge and returned word
  always_comb begin
    acc_c    = ram_en && (state == S_IDLE) && !sys_rst;
    wr_c     = acc_c && ram_wea;
    old_c    = mem[ram_addr];
    merged_c = old_c;
    for (int i = 0; i < NB; i++) begin
      if (ram_be[i]) merged_c[8*i +: 8] = ram_wr_data[8*i +: 8];
    end
    ret_c = (wr_c && (WR_MODE == 1)) ? merged_c : old_c;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clr_req) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, clear counter and busy flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      clr_cnt  <= '0;
      ram_busy <= (CLR_ON_RST != 0);
    end else begin
      state    <= state_nxt;
      ram_busy <= (state_nxt == S_CLEAR);
      if (state == S_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Array is never reset; the clear engine owns the write port while busy
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (state == S_CLEAR) mem[clr_cnt] <= '0;
      else if (wr_c)        mem[ram_addr] <= merged_c;
    end
  end

  // Read pipeline; data holds between valid pulses
  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        s1_data      <= '0;
        s1_valid     <= 1'b0;
        ram_rd_data  <= '0;
        ram_rd_valid <= 1'b0;
      end else begin
        s1_valid     <= acc_c;
        ram_rd_valid <= s1_valid;
        if (acc_c)    s1_data     <= ret_c;
        if (s1_valid) ram_rd_data <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        ram_rd_data  <= '0;
        ram_rd_valid <= 1'b0;
      end else begin
        ram_rd_valid <= acc_c;
        if (acc_c) ram_rd_data <= ret_c;
      end
    end
  end

endmodule
